// File: rtl/reg_dump_reader.sv
// Register-file dump reader: walks rf_addr over a wrapping 4-bit range,
// waits for read data to settle, and presents each word on a valid/ready port.
module reg_dump_reader #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  first_reg,
    input  logic [3:0]  last_reg,
    output logic [3:0]  rf_addr,
    input  logic [31:0] rf_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [3:0]  out_idx,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SAMPLE,
        HOLD,
        FINISH
    } state_t;

    localparam logic [2:0] SETTLE_LOAD = 3'(SETTLE_CYCLES);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  last_q, last_d;
    logic [3:0]  addr_q, addr_d;
    logic        valid_q, valid_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  idx_q, idx_d;
    logic        olast_q, olast_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // Next-state and next-output computation for the dump sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        data_d  = data_q;
        idx_d   = idx_q;
        olast_d = olast_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    last_d  = last_reg;
                    addr_d  = first_reg;
                    cnt_d   = SETTLE_LOAD;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                // Address has been stable for the full settle window once
                // the counter would hit zero.
                cnt_d = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                data_d  = rf_data;
                idx_d   = addr_q;
                olast_d = (addr_q == last_q);
                valid_d = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    if (olast_q) begin
                        done_d  = 1'b1;
                        state_d = FINISH;
                    end else begin
                        addr_d  = addr_q + 4'd1;
                        cnt_d   = SETTLE_LOAD;
                        state_d = SETUP;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset abandons any dump in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            last_q  <= 4'd0;
            addr_q  <= 4'd0;
            valid_q <= 1'b0;
            data_q  <= 32'd0;
            idx_q   <= 4'd0;
            olast_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            olast_q <= olast_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign rf_addr   = addr_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_idx   = idx_q;
    assign out_last  = olast_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Bench for reg_dump_reader: register-file model, word-queue reference
// model checked every cycle, plus directed literal expectations.
module tb_reg_dump_reader;

    localparam int SETTLE = 1;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  first_reg;
    logic [3:0]  last_reg;
    logic [3:0]  rf_addr;
    logic [31:0] rf_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_idx;
    logic        out_last;
    logic        busy;
    logic        done;

    reg_dump_reader #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .first_reg(first_reg),
        .last_reg(last_reg),
        .rf_addr(rf_addr),
        .rf_data(rf_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_idx(out_idx),
        .out_last(out_last),
        .busy(busy),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  idx;
        logic [31:0] data;
        logic        last;
        int          cyc;
    } word_t;

    logic [31:0] rf [16];
    word_t       q[$];
    word_t       lg[$];
    int          checks = 0;
    int          errors = 0;
    int          dones = 0;
    int          cyc = 0;
    bit          open = 0;
    bit          done_due = 0;

    initial begin
        rf[0] = 32'h0;
        rf[1] = 32'h10000;
        rf[2] = 32'h20000;
        rf[3] = 32'h20100;
        rf[4] = 32'h20200;
        for (int i = 5; i < 16; i++) rf[i] = 32'hA500_0000 + i;
    end

    // Register file read port: data follows address on the falling edge.
    always @(negedge clk) rf_data <= rf[rf_addr];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model and per-cycle compare.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_outputs_zero",
                {rf_addr, out_valid, out_data, out_idx, out_last, busy, done},
                64'd0);
            q.delete();
            open = 0;
            done_due = 0;
        end else begin
            chk("done_pulse", done, done_due);
            chk("busy", busy, open);
            if (done) begin
                dones++;
                chk("done_queue_empty", q.size(), 0);
            end
            done_due = 0;
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_word", out_valid, 1'b0);
                end else begin
                    chk("out_idx", out_idx, q[0].idx);
                    chk("out_data", out_data, q[0].data);
                    chk("out_last", out_last, q[0].last);
                    chk("rf_addr_hold", rf_addr, q[0].idx);
                    if (out_ready) begin
                        word_t w;
                        w = q[0];
                        w.cyc = cyc;
                        lg.push_back(w);
                        if (q[0].last) done_due = 1;
                        void'(q.pop_front());
                    end
                end
            end
            if (start && !open) begin
                logic [3:0] diff;
                int n;
                diff = last_reg - first_reg;
                n = int'(diff) + 1;
                for (int k = 0; k < n; k++) begin
                    word_t w;
                    w.idx = first_reg + 4'(k);
                    w.data = rf[w.idx];
                    w.last = (k == n - 1);
                    w.cyc = 0;
                    q.push_back(w);
                end
                open = 1;
            end
            if (done) open = 0;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [3:0] f, input logic [3:0] l);
        first_reg = f;
        last_reg = l;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int d0;
        bit ok;
        d0 = dones;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (dones > d0) begin
                ok = 1;
                break;
            end
        end
        chk("done_timeout", ok, 1'b1);
    endtask

    task automatic wait_word(input logic [3:0] idx);
        bit ok;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (out_valid && out_idx == idx) begin
                ok = 1;
                break;
            end
        end
        chk("word_timeout", ok, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        first_reg = 4'd0;
        last_reg = 4'd0;
        out_ready = 1'b1;
        repeat (2) tick();
        chk("reset_rf_addr", rf_addr, 4'd0);
        chk("reset_valid", out_valid, 1'b0);
        chk("reset_data", out_data, 32'd0);
        chk("reset_busy_done", {busy, done}, 2'b00);
        rst = 1'b0;
        repeat (2) tick();

        // Range 1..3 with ready held high
        lg.delete();
        pulse_start(4'd1, 4'd3);
        wait_done();
        tick();
        chk("t1_count", lg.size(), 3);
        if (lg.size() == 3) begin
            chk("t1_w0", {lg[0].idx, lg[0].data, lg[0].last},
                {4'd1, 32'h10000, 1'b0});
            chk("t1_w1", {lg[1].idx, lg[1].data, lg[1].last},
                {4'd2, 32'h20000, 1'b0});
            chk("t1_w2", {lg[2].idx, lg[2].data, lg[2].last},
                {4'd3, 32'h20100, 1'b1});
            chk("t1_rate", lg[1].cyc - lg[0].cyc, SETTLE + 2);
            chk("t1_rate2", lg[2].cyc - lg[1].cyc, SETTLE + 2);
        end

        // Single word
        lg.delete();
        pulse_start(4'd4, 4'd4);
        wait_done();
        tick();
        chk("t2_count", lg.size(), 1);
        if (lg.size() == 1)
            chk("t2_w0", {lg[0].idx, lg[0].data, lg[0].last},
                {4'd4, 32'h20200, 1'b1});

        // Wrapping range 14..1
        lg.delete();
        pulse_start(4'd14, 4'd1);
        wait_done();
        tick();
        chk("t3_count", lg.size(), 4);
        if (lg.size() == 4) begin
            chk("t3_idx", {lg[0].idx, lg[1].idx, lg[2].idx, lg[3].idx},
                {4'd14, 4'd15, 4'd0, 4'd1});
            chk("t3_last", {lg[0].last, lg[1].last, lg[2].last, lg[3].last},
                4'b0001);
        end

        // Back-pressure on index 2
        lg.delete();
        pulse_start(4'd1, 4'd3);
        wait_word(4'd2);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("t4_stall_data", out_data, 32'h20000);
            chk("t4_stall_addr", {out_valid, rf_addr}, {1'b1, 4'd2});
            tick();
        end
        out_ready = 1'b1;
        wait_done();
        tick();
        chk("t4_count", lg.size(), 3);
        if (lg.size() == 3)
            chk("t4_idx", {lg[0].idx, lg[1].idx, lg[2].idx},
                {4'd1, 4'd2, 4'd3});

        // Reset while holding index 2
        pulse_start(4'd1, 4'd3);
        wait_word(4'd2);
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("t5_async_zero",
            {rf_addr, out_valid, out_data, out_idx, out_last, busy, done},
            64'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        lg.delete();
        pulse_start(4'd0, 4'd0);
        wait_done();
        tick();
        chk("t5_count", lg.size(), 1);
        if (lg.size() == 1)
            chk("t5_w0", {lg[0].idx, lg[0].data, lg[0].last},
                {4'd0, 32'h0, 1'b1});

        // Start re-pulsed mid-dump and in the done cycle
        lg.delete();
        begin
            int d0;
            d0 = dones;
            pulse_start(4'd2, 4'd4);
            for (int i = 0; i < 300; i++) begin
                tick();
                if (dones > d0) break;
                start = (i == 3 || i == 4 || done);
            end
            start = 1'b0;
            repeat (10) tick();
            chk("t6_one_done", dones - d0, 1);
        end
        chk("t6_count", lg.size(), 3);
        if (lg.size() == 3)
            chk("t6_idx", {lg[0].idx, lg[1].idx, lg[2].idx},
                {4'd2, 4'd3, 4'd4});
        chk("total_dones", dones, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
